// File: rtl/bcd_subtractor_seq.sv
// Digit-serial BCD subtractor: |A-B| one digit per clock, LS digit first,
// with a sign flag and a non-BCD input flag behind a start/busy/done handshake.
module bcd_subtractor_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                flag
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, CMP, DONE} state_t;

    state_t               state, state_nxt;
    logic [DIGITS-1:0][3:0] opa, opb, res, res_nxt, in_a, in_b;
    logic [IW-1:0]        idx;
    logic                 borrow, borrow_nxt, last, bad_in;
    logic [3:0]           m_dig, s_dig, dig;
    logic [4:0]           t;

    assign in_a = a;
    assign in_b = b;
    assign last = (idx == IW'(DIGITS - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (in_a[i] > 4'd9 || in_b[i] > 4'd9) bad_in = 1'b1;
    end

    // CMP reuses the SUB digit slice to form 0 - result (ten's complement -> magnitude)
    always_comb begin
        m_dig = (state == CMP) ? 4'd0 : opa[idx];
        s_dig = (state == CMP) ? res[idx] : opb[idx];
        t = {1'b0, m_dig} - {1'b0, s_dig} - {4'd0, borrow};
        borrow_nxt = t[4];
        dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        res_nxt = res;
        res_nxt[idx] = dig;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = bad_in ? DONE : SUB;
            SUB:  if (last)  state_nxt = borrow_nxt ? CMP : DONE;
            CMP:  if (last)  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            neg    <= 1'b0;
            flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opa    <= in_a;
                    opb    <= in_b;
                    idx    <= '0;
                    borrow <= 1'b0;
                    if (bad_in) begin
                        diff <= '0;
                        neg  <= 1'b0;
                        flag <= 1'b1;
                    end else begin
                        flag <= 1'b0;
                    end
                end
                SUB: begin
                    res <= res_nxt;
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        if (!borrow_nxt) begin
                            diff <= res_nxt;
                            neg  <= 1'b0;
                        end
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= borrow_nxt;
                    end
                end
                CMP: begin
                    res <= res_nxt;
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        diff   <= res_nxt;
                        neg    <= 1'b1;
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= borrow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Directed bench for bcd_subtractor_seq (DIGITS=4) with hand-computed results.
module tb_bcd_subtractor_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, neg, flag;
    logic [15:0] diff;
    int total = 0;
    int bad = 0;

    bcd_subtractor_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .neg(neg), .flag(flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; expect done in cycle ecyc (edge 0 samples start).
    task automatic run(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                       input int ecyc, input logic [15:0] ediff, input logic eneg, input logic eflag);
        int cyc;
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        start = 1'b0;
        a = 16'hFFFF; b = 16'hAAAA;  // operands are latched; scramble inputs
        while (!done && cyc < 40) begin
            chk({tag, "_busy"}, busy, 1);
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_cycle"}, cyc, ecyc);
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_diff"}, diff, ediff);
        chk({tag, "_neg"}, neg, eneg);
        chk({tag, "_flag"}, flag, eflag);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int cyc, ndone;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_neg", neg, 0);
        chk("rst_flag", flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("t1", 16'h1234, 16'h0567, 5, 16'h0667, 0, 0);
        run("t2", 16'h0567, 16'h1234, 9, 16'h0667, 1, 0);
        run("t3a", 16'h1000, 16'h0001, 5, 16'h0999, 0, 0);
        run("t3b", 16'h4321, 16'h4321, 5, 16'h0000, 0, 0);
        run("t3c", 16'h0000, 16'h9999, 9, 16'h9999, 1, 0);
        run("t4a", 16'h12A4, 16'h0001, 1, 16'h0000, 0, 1);
        run("t4b", 16'h0010, 16'h0005, 5, 16'h0005, 0, 0);

        // Test 5: start pulse during busy cycle 3 is ignored
        a = 16'h1234; b = 16'h0567; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1; ndone = 0;
        while (cyc < 5) begin
            if (done) ndone++;
            if (cyc == 3) start = 1'b1;
            else start = 1'b0;
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        chk("t5_done5", done, 1);
        chk("t5_diff", diff, 16'h0667);
        chk("t5_early_done", ndone, 0);
        // hold start high: next op accepted on first IDLE cycle
        a = 16'h1000; b = 16'h0001; start = 1'b1;
        ndone = 0;
        @(negedge clk); cyc++;
        chk("t5_idle6", busy, 0);
        while (!done && cyc < 40) begin
            if (cyc == 8) chk("t5_hold_diff", diff, 16'h0667);
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        chk("t5_cycle2", cyc, 11);
        chk("t5_diff2", diff, 16'h0999);
        @(negedge clk);
        chk("t5_pulse2", done, 0);
        repeat (2) @(negedge clk);

        // Test 6: reset mid-operation aborts without done
        a = 16'h0567; b = 16'h1234; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_diff", diff, 0);
        chk("t6_neg", neg, 0);
        chk("t6_done", done, 0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t6_no_done", ndone, 0);
        run("t6_new", 16'h0567, 16'h1234, 9, 16'h0667, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_subtractor_seq.md
Name: bcd_subtractor_seq

Overview:
- Digit-serial multi-digit BCD subtractor; the inverse operation of the team's combinational BCD adder.
- Computes |A − B| as packed BCD plus a sign flag, one digit per clock, LS digit first.
- A start/busy/done handshake lets a controller FSM or datapath sequencer issue operations to it.
- Sets an error flag on non-BCD input digits, matching the adder's flag semantics.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
b  input  4*DIGITS  subtrahend, packed BCD
busy  output  1  high whenever state ≠ IDLE
done  output  1  one-cycle pulse, result valid
diff  output  4*DIGITS  |A−B| packed BCD
neg  output  1  1 when A < B
flag  output  1  1 when any input digit > 9

Behaviour:
- Interface: one clock (clk); synchronous active-low reset rst_n. Reset is sampled on the rising clk edge, with no asynchronous path.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - diff=0, neg=0, flag=0, done=0, busy=0.
  - Internal operand and borrow registers are cleared.
  - Reset mid-operation aborts the operation, and no done pulse is produced.
- FSM states: IDLE, SUB, CMP, DONE.
- IDLE:
  - start=1 latches a, b into internal registers and clears the digit index and borrow.
  - If any digit of a or b is > 9, go to DONE with diff=0, neg=0, flag=1.
  - Otherwise clear flag and go to SUB.
- SUB, one digit per cycle, index i = 0..DIGITS−1:
  - t = a_i − b_i − borrow, 5-bit signed.
  - If t < 0: digit = t+10 and borrow=1; else digit = t and borrow=0.
  - The digit is written into the result register at position i.
  - After digit DIGITS−1: borrow=0 → DONE with neg=0; borrow=1 → CMP with neg=1. The result then holds the ten's complement.
- CMP, DIGITS cycles:
  - Recomputes result = 0 − result digit-serially with the same rule, borrow starting at 0.
  - This yields the magnitude.
  - After the last digit → DONE.
- DONE:
  - done=1 for exactly one cycle; diff, neg and flag are valid.
  - Next state is IDLE.
- Latency, with edge 0 = the edge sampling start:
  - done is high in cycle DIGITS+1 for A ≥ B.
  - done is high in cycle 2*DIGITS+1 for A < B.
  - done is high in cycle 1 for invalid input.
- Output stability:
  - diff, neg and flag hold their values from DONE until the next accepted start.
  - They do not change during the next operation's SUB/CMP; the internal result register is separate and diff is updated on entry to DONE.
- Handshake:
  - start while busy=1 is ignored and not queued.
  - start held high continuously restarts immediately on the first IDLE cycle after DONE, i.e. back-to-back operations every DIGITS+2 cycles.
- a and b may change freely after the start edge, because the operands are latched.
- Zero result: A=B gives diff=0 and neg=0, never −0.

Test Plan (DIGITS=4):
- 1. Reset, then start with a=0x1234, b=0x0567 → done in cycle 5, diff=0x0667, neg=0, flag=0, busy high cycles 1–5.
- 2. a=0x0567, b=0x1234 → done in cycle 9, diff=0x0667, neg=1, flag=0.
- 3. Borrow chain and equality:
  - a=0x1000, b=0x0001 → diff=0x0999, neg=0.
  - a=0x4321, b=0x4321 → diff=0x0000, neg=0.
  - a=0x0000, b=0x9999 → diff=0x9999, neg=1.
- 4. Invalid digits: a=0x12A4, b=0x0001 → done in cycle 1, diff=0, neg=0, flag=1. Then a valid op clears flag.
- 5. Pulse start again during busy cycle 3 of a 1234−0567 op → ignored, single done pulse, result unchanged. Hold start high → second done exactly 6 cycles after the first.
- 6. Assert rst_n=0 in cycle 3 of 0567−1234 → next cycle: busy=0, diff=0, neg=0, no done pulse. A new op then completes correctly.
